// File: rtl/fpu_issue.sv
// fpu_issue: request FIFO, single-issue credit logic and in-order response buffer in front of fpu.
// Optional sticky fflags accumulator built when FPU_ISSUE_FFLAGS_EN is defined.
module fpu_issue #(
  parameter int C_DEPTH = 4,
  parameter int C_TAG   = 5
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic             Req_Valid_SI,
  output logic             Req_Ready_SO,
  input  logic [31:0]      Req_Operand_a_DI,
  input  logic [31:0]      Req_Operand_b_DI,
  input  logic [6:0]       Req_OP_SI,
  input  logic [2:0]       Req_RM_SI,
  input  logic [C_TAG-1:0] Req_Tag_DI,
  output logic [31:0]      Fpu_Operand_a_DO,
  output logic [31:0]      Fpu_Operand_b_DO,
  output logic [6:0]       Fpu_OP_SO,
  output logic [2:0]       Fpu_RM_SO,
  output logic             Fpu_Enable_SO,
  input  logic [31:0]      Fpu_Result_DI,
  input  logic             Fpu_IV_SI,
  input  logic             Fpu_OF_SI,
  input  logic             Fpu_UF_SI,
  input  logic             Fpu_IX_SI,
  output logic             Rsp_Valid_SO,
  input  logic             Rsp_Ready_SI,
  output logic [31:0]      Rsp_Result_DO,
  output logic [C_TAG-1:0] Rsp_Tag_DO,
  output logic [4:0]       Rsp_Flags_DO,
  output logic [4:0]       Fflags_DO,
  input  logic             Fflags_Clr_SI,
  output logic             Busy_SO
);

  localparam int AW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [6:0]       op;
    logic [2:0]       rm;
    logic [C_TAG-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [31:0]      res;
    logic [C_TAG-1:0] tag;
    logic [4:0]       flg;
  } rsp_t;

  req_t             fifo_q [C_DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;

  rsp_t             rbuf_q [2];
  logic             rwr_q;
  logic             rrd_q;
  logic [1:0]       rcnt_q;

  logic             inflight_q;
  logic [C_TAG-1:0] itag_q;

  logic             push;
  logic             issue;
  logic             rsp_pop;
  logic [2:0]       occ;
  req_t             head;
  rsp_t             rhead;
  rsp_t             cap;

  assign Req_Ready_SO = cnt_q < (AW+1)'(C_DEPTH);
  assign push         = Req_Valid_SI & Req_Ready_SO;
  assign head         = fifo_q[rd_q];

  assign Rsp_Valid_SO = rcnt_q != 2'd0;
  assign rsp_pop      = Rsp_Valid_SO & Rsp_Ready_SI;
  assign rhead        = rbuf_q[rrd_q];

  // Slots still owed to the response buffer after this cycle's pop.
  assign occ = {2'b0, inflight_q}
             + {1'b0, rcnt_q}
             - {2'b0, rsp_pop};

  assign issue = (cnt_q != '0) && (occ < 3'd2);

  assign cap.res = Fpu_Result_DI;
  assign cap.tag = itag_q;
  assign cap.flg = {Fpu_IV_SI, 1'b0, Fpu_OF_SI,
                    Fpu_UF_SI, Fpu_IX_SI};

  // Request FIFO storage; data needs no reset.
  always_ff @(posedge Clk_CI) begin
    if (push) begin
      fifo_q[wr_q].a   <= Req_Operand_a_DI;
      fifo_q[wr_q].b   <= Req_Operand_b_DI;
      fifo_q[wr_q].op  <= Req_OP_SI;
      fifo_q[wr_q].rm  <= Req_RM_SI;
      fifo_q[wr_q].tag <= Req_Tag_DI;
    end
  end

  // Request FIFO pointers and occupancy.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push)
        wr_q <= wr_q + AW'(1);
      if (issue)
        rd_q <= rd_q + AW'(1);
      unique case ({push, issue})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Track the single op inside fpu and its tag.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      inflight_q <= 1'b0;
      itag_q     <= '0;
    end else begin
      inflight_q <= issue;
      if (issue)
        itag_q <= head.tag;
    end
  end

  // Drive fpu only in the issue cycle, zeros otherwise.
  always_comb begin
    Fpu_Enable_SO    = 1'b0;
    Fpu_Operand_a_DO = '0;
    Fpu_Operand_b_DO = '0;
    Fpu_OP_SO        = '0;
    Fpu_RM_SO        = '0;
    if (issue) begin
      Fpu_Enable_SO    = 1'b1;
      Fpu_Operand_a_DO = head.a;
      Fpu_Operand_b_DO = head.b;
      Fpu_OP_SO        = head.op;
      Fpu_RM_SO        = head.rm;
    end
  end

  // Response buffer storage; result is valid only while inflight_q.
  always_ff @(posedge Clk_CI) begin
    if (inflight_q)
      rbuf_q[rwr_q] <= cap;
  end

  // Response buffer pointers and occupancy.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      rwr_q  <= 1'b0;
      rrd_q  <= 1'b0;
      rcnt_q <= 2'd0;
    end else begin
      if (inflight_q)
        rwr_q <= ~rwr_q;
      if (rsp_pop)
        rrd_q <= ~rrd_q;
      unique case ({inflight_q, rsp_pop})
        2'b10:   rcnt_q <= rcnt_q + 2'd1;
        2'b01:   rcnt_q <= rcnt_q - 2'd1;
        default: rcnt_q <= rcnt_q;
      endcase
    end
  end

  // Head of response buffer, zeroed when empty.
  always_comb begin
    Rsp_Result_DO = '0;
    Rsp_Tag_DO    = '0;
    Rsp_Flags_DO  = '0;
    if (Rsp_Valid_SO) begin
      Rsp_Result_DO = rhead.res;
      Rsp_Tag_DO    = rhead.tag;
      Rsp_Flags_DO  = rhead.flg;
    end
  end

`ifdef FPU_ISSUE_FFLAGS_EN
  logic [4:0] fflags_q;

  // Sticky flags; a same-cycle accrue survives a clear.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI)
      fflags_q <= '0;
    else
      fflags_q <= (Fflags_Clr_SI ? 5'd0 : fflags_q)
                | (rsp_pop ? Rsp_Flags_DO : 5'd0);
  end

  assign Fflags_DO = fflags_q;
`else
  logic unused_clr;

  assign unused_clr = Fflags_Clr_SI;
  assign Fflags_DO  = '0;
`endif

  assign Busy_SO = (cnt_q != '0) | inflight_q
                 | (rcnt_q != 2'd0);

endmodule
